// File: rtl/bp_fe_bp_gshare_if.sv
// Request/response bundle between the front end, the gshare predictor and
// the backend resolution path.
interface bp_fe_bp_gshare_if #(
    parameter int unsigned bht_idx_width_p = 9,
    parameter int unsigned ghist_width_p   = 8
);
    logic                       ready_o;
    logic                       r_v_i;
    logic [bht_idx_width_p-1:0] idx_r_i;
    logic                       predict_v_o;
    logic                       predict_o;
    logic [ghist_width_p-1:0]   ghist_o;
    logic                       w_v_i;
    logic [bht_idx_width_p-1:0] idx_w_i;
    logic [ghist_width_p-1:0]   ghist_w_i;
    logic                       taken_i;
    logic                       mispredict_i;

    modport master (
        input  ready_o, predict_v_o, predict_o, ghist_o,
        output r_v_i, idx_r_i, w_v_i, idx_w_i, ghist_w_i, taken_i, mispredict_i
    );

    modport slave (
        output ready_o, predict_v_o, predict_o, ghist_o,
        input  r_v_i, idx_r_i, w_v_i, idx_w_i, ghist_w_i, taken_i, mispredict_i
    );
endinterface

// File: rtl/bp_fe_bp_gshare.sv
// Gshare direction predictor: (index XOR global history) selects a saturating
// counter; speculative history update on predict, repair on mispredict.
module bp_fe_bp_gshare #(
    parameter int unsigned bht_idx_width_p   = 9,
    parameter int unsigned bp_cnt_sat_bits_p = 2,
    parameter int unsigned ghist_width_p     = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    bp_fe_bp_gshare_if.slave        bp_if
);
    localparam int unsigned entries_lp = 1 << bht_idx_width_p;
    localparam logic [bp_cnt_sat_bits_p-1:0] cnt_init_lp =
        bp_cnt_sat_bits_p'((1 << (bp_cnt_sat_bits_p - 1)) - 1);

    typedef enum logic {
        e_init,
        e_ready
    } state_e;

    state_e                       state_q, state_d;
    logic [bht_idx_width_p-1:0]   init_ptr_q, init_ptr_d;
    logic [ghist_width_p-1:0]     ghr_q, ghr_d;
    logic [ghist_width_p-1:0]     ghist_q, ghist_d;
    logic                         predict_v_q, predict_v_d;
    logic                         predict_q, predict_d;

    logic [bp_cnt_sat_bits_p-1:0] bht_q [entries_lp];

    logic                         ready;
    logic                         rd_acc, wr_acc, rd_bit;
    logic [bht_idx_width_p-1:0]   rd_idx, wr_idx;
    logic [bp_cnt_sat_bits_p-1:0] rd_cnt, wr_cnt_old;
    logic                         bht_we;
    logic [bht_idx_width_p-1:0]   bht_waddr;
    logic [bp_cnt_sat_bits_p-1:0] bht_wdata;

    always_comb begin
        state_d     = state_q;
        init_ptr_d  = init_ptr_q;
        ghr_d       = ghr_q;
        ghist_d     = ghist_q;
        predict_v_d = 1'b0;
        predict_d   = predict_q;
        bht_we      = 1'b0;
        bht_waddr   = '0;
        bht_wdata   = '0;

        ready  = (state_q == e_ready);
        rd_acc = bp_if.r_v_i & ready;
        wr_acc = bp_if.w_v_i & ready;

        rd_idx     = bp_if.idx_r_i ^ bht_idx_width_p'(ghr_q);
        rd_cnt     = bht_q[rd_idx];
        rd_bit     = rd_cnt[bp_cnt_sat_bits_p-1];
        wr_idx     = bp_if.idx_w_i ^ bht_idx_width_p'(bp_if.ghist_w_i);
        wr_cnt_old = bht_q[wr_idx];

        unique case (state_q)
            e_init: begin
                bht_we     = 1'b1;
                bht_waddr  = init_ptr_q;
                bht_wdata  = cnt_init_lp;
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == '1) state_d = e_ready;
            end
            e_ready: begin
                bht_we    = wr_acc;
                bht_waddr = wr_idx;
                if (bp_if.taken_i)
                    bht_wdata = (wr_cnt_old == '1) ? wr_cnt_old : wr_cnt_old + 1'b1;
                else
                    bht_wdata = (wr_cnt_old == '0) ? wr_cnt_old : wr_cnt_old - 1'b1;
            end
        endcase

        if (rd_acc) begin
            predict_v_d = 1'b1;
            predict_d   = rd_bit;
            ghist_d     = ghr_q;
            ghr_d       = ghist_width_p'({ghr_q, rd_bit});
        end
        // Repair wins over a same-cycle speculative shift.
        if (wr_acc && bp_if.mispredict_i)
            ghr_d = ghist_width_p'({bp_if.ghist_w_i, bp_if.taken_i});
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= e_init;
            init_ptr_q  <= '0;
            ghr_q       <= '0;
            ghist_q     <= '0;
            predict_v_q <= 1'b0;
            predict_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_ptr_q  <= init_ptr_d;
            ghr_q       <= ghr_d;
            ghist_q     <= ghist_d;
            predict_v_q <= predict_v_d;
            predict_q   <= predict_d;
        end
    end

    // Table has no reset so it can map to a 1R1W RAM; INIT sweeps it instead.
    always_ff @(posedge clk_i) begin
        if (bht_we) bht_q[bht_waddr] <= bht_wdata;
    end

    assign bp_if.ready_o     = ready;
    assign bp_if.predict_v_o = predict_v_q;
    assign bp_if.predict_o   = predict_q;
    assign bp_if.ghist_o     = ghist_q;
endmodule

// File: tb/tb_bp_fe_bp_gshare.sv
// Directed bench for bp_fe_bp_gshare with hand-computed counter/GHR values.
module tb_bp_fe_bp_gshare;
    localparam int unsigned W = 9;
    localparam int unsigned C = 2;
    localparam int unsigned G = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bp_fe_bp_gshare_if #(.bht_idx_width_p(W), .ghist_width_p(G)) bp_if ();

    bp_fe_bp_gshare #(
        .bht_idx_width_p  (W),
        .bp_cnt_sat_bits_p(C),
        .ghist_width_p    (G)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bp_if  (bp_if)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bp_if.r_v_i        = 1'b0;
        bp_if.idx_r_i      = '0;
        bp_if.w_v_i        = 1'b0;
        bp_if.idx_w_i      = '0;
        bp_if.ghist_w_i    = '0;
        bp_if.taken_i      = 1'b0;
        bp_if.mispredict_i = 1'b0;
    endtask

    task automatic rd(input logic [W-1:0] idx, input logic exp_p, input logic [G-1:0] exp_g,
                      input string tag);
        bp_if.r_v_i   = 1'b1;
        bp_if.idx_r_i = idx;
        tick();
        bp_if.r_v_i = 1'b0;
        chk({tag, "_v"}, 32'(bp_if.predict_v_o), 32'd1);
        chk({tag, "_p"}, 32'(bp_if.predict_o), 32'(exp_p));
        chk({tag, "_g"}, 32'(bp_if.ghist_o), 32'(exp_g));
    endtask

    task automatic wr(input logic [W-1:0] idx, input logic [G-1:0] gh, input logic tk,
                      input logic mp);
        bp_if.w_v_i        = 1'b1;
        bp_if.idx_w_i      = idx;
        bp_if.ghist_w_i    = gh;
        bp_if.taken_i      = tk;
        bp_if.mispredict_i = mp;
        tick();
        bp_if.w_v_i        = 1'b0;
        bp_if.mispredict_i = 1'b0;
    endtask

    // Forces GHR back to zero via a mispredict write to a scratch entry.
    task automatic clr_ghr();
        wr(9'h1F0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic wait_ready(input string tag);
        int  cyc = 0;
        bit  saw_pv = 1'b0;
        while (!bp_if.ready_o && cyc < 2000) begin
            tick();
            cyc++;
            if (bp_if.predict_v_o) saw_pv = 1'b1;
        end
        chk({tag, "_cycles"}, 32'(cyc), 32'd512);
        chk({tag, "_no_pv"}, 32'(saw_pv), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        idle_in();
        rst = 1'b1;
        #12;
        chk("rst_ready", 32'(bp_if.ready_o), 32'd0);
        chk("rst_pv", 32'(bp_if.predict_v_o), 32'd0);
        chk("rst_p", 32'(bp_if.predict_o), 32'd0);
        chk("rst_g", 32'(bp_if.ghist_o), 32'd0);
        #1 rst = 1'b0;
        wait_ready("init1");

        // Freshly initialised entries predict not-taken.
        rd(9'h123, 1'b0, 8'h00, "t1_rd");
        tick();
        chk("t1_idle_pv", 32'(bp_if.predict_v_o), 32'd0);

        // Counter walk on entry 5 (01 -> 11 saturate -> 00 saturate -> 10).
        repeat (3) wr(9'h005, 8'h00, 1'b1, 1'b0);
        rd(9'h005, 1'b1, 8'h00, "t2_cnt11");
        clr_ghr();
        repeat (2) wr(9'h005, 8'h00, 1'b1, 1'b0);
        wr(9'h005, 8'h00, 1'b0, 1'b0);
        rd(9'h005, 1'b1, 8'h00, "t2_sat_hi");
        clr_ghr();
        wr(9'h005, 8'h00, 1'b0, 1'b0);
        rd(9'h005, 1'b0, 8'h00, "t2_cnt01");
        repeat (2) wr(9'h005, 8'h00, 1'b0, 1'b0);
        wr(9'h005, 8'h00, 1'b1, 1'b0);
        rd(9'h005, 1'b0, 8'h00, "t2_sat_lo");
        wr(9'h005, 8'h00, 1'b1, 1'b0);
        rd(9'h005, 1'b1, 8'h00, "t2_cnt10");
        clr_ghr();

        // Speculative history: T, NT, T from GHR=0.
        repeat (2) wr(9'h0A0, 8'h02, 1'b1, 1'b0);
        rd(9'h005, 1'b1, 8'h00, "t3_a");
        rd(9'h040, 1'b0, 8'h01, "t3_b");
        rd(9'h0A0, 1'b1, 8'h02, "t3_c");
        rd(9'h100, 1'b0, 8'h05, "t3_after");

        // Same-cycle read and mispredict repair, GHR was 0x0A.
        bp_if.r_v_i        = 1'b1;
        bp_if.idx_r_i      = 9'h000;
        bp_if.w_v_i        = 1'b1;
        bp_if.idx_w_i      = 9'h180;
        bp_if.ghist_w_i    = 8'h3C;
        bp_if.taken_i      = 1'b1;
        bp_if.mispredict_i = 1'b1;
        tick();
        idle_in();
        chk("t4_v", 32'(bp_if.predict_v_o), 32'd1);
        chk("t4_p", 32'(bp_if.predict_o), 32'd0);
        chk("t4_g", 32'(bp_if.ghist_o), 32'h0A);
        rd(9'h000, 1'b0, 8'h79, "t4_after");

        // Read-before-write on entry 0xE2 (GHR=0xF2).
        bp_if.r_v_i     = 1'b1;
        bp_if.idx_r_i   = 9'h010;
        bp_if.w_v_i     = 1'b1;
        bp_if.idx_w_i   = 9'h0E2;
        bp_if.ghist_w_i = 8'h00;
        bp_if.taken_i   = 1'b1;
        tick();
        idle_in();
        chk("t5_p", 32'(bp_if.predict_o), 32'd0);
        chk("t5_g", 32'(bp_if.ghist_o), 32'hF2);
        rd(9'h006, 1'b1, 8'hE4, "t5_after");

        // Reset one cycle after an accepted read: outputs clear without an edge.
        #1 rst = 1'b1;
        #1;
        chk("t6a_ready", 32'(bp_if.ready_o), 32'd0);
        chk("t6a_pv", 32'(bp_if.predict_v_o), 32'd0);
        chk("t6a_p", 32'(bp_if.predict_o), 32'd0);
        chk("t6a_g", 32'(bp_if.ghist_o), 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;

        // Traffic during INIT must be ignored; reset again at ptr=100.
        bp_if.r_v_i        = 1'b1;
        bp_if.idx_r_i      = 9'h005;
        bp_if.w_v_i        = 1'b1;
        bp_if.idx_w_i      = 9'h005;
        bp_if.ghist_w_i    = 8'h55;
        bp_if.taken_i      = 1'b1;
        bp_if.mispredict_i = 1'b1;
        begin
            bit saw = 1'b0;
            for (int i = 0; i < 100; i++) begin
                tick();
                if (bp_if.predict_v_o) saw = 1'b1;
            end
            chk("t6_init_no_pv", 32'(saw), 32'd0);
        end
        #1 rst = 1'b1;
        #1;
        chk("t6b_ready", 32'(bp_if.ready_o), 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        wait_ready("init2");
        idle_in();

        rd(9'h005, 1'b0, 8'h00, "t6_reinit");
        rd(9'h0E2, 1'b0, 8'h00, "t6_reinit_e2");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
